// File: rtl/rr_scoreboard.sv
// Register-read hazard scoreboard: per-register outstanding-write counters drive RR_stall.
// Optional RR_SCOREBOARD_WB_BYPASS_EN lets a consumer issue in its last producer's WB cycle.
module rr_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [IDX_W-1:0]    src1_idx,
  input  logic [IDX_W-1:0]    src2_idx,
  input  logic                src2_is_imm,
  input  logic                dst_we,
  input  logic [IDX_W-1:0]    dst_idx,
  input  logic                flush,
  input  logic                we,
  input  logic [IDX_W-1:0]    widx,
  output logic                RR_stall,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wb_clear;
  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic                haz;

  always_comb begin
    busy     = '0;
    wb_clear = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      busy[i] = (cnt[i] != '0);
`ifdef RR_SCOREBOARD_WB_BYPASS_EN
      // Last outstanding write lands this cycle; regfile write-through supplies the value.
      wb_clear[i] = we && (widx == IDX_W'(i)) && (cnt[i] == CNT_ONE);
`else
      wb_clear[i] = 1'b0;
`endif
    end
    hit = busy & ~wb_clear;
  end

  always_comb begin
    haz = hit[src1_idx]
        | (~src2_is_imm & hit[src2_idx])
        | (dst_we & (cnt[dst_idx] == CNT_MAX));
    RR_stall   = issue_valid & haz & ~flush;
    issue_fire = issue_valid & ~haz & ~flush;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc[r] = issue_fire & dst_we & (dst_idx == IDX_W'(r));
      dec[r] = we & (widx == IDX_W'(r)) & busy[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        // Saturation is enforced by the dst==MAX stall, so inc never sees a full counter.
        case ({inc[r], dec[r]})
          2'b10:   cnt[r] <= cnt[r] + CNT_ONE;
          2'b01:   cnt[r] <= cnt[r] - CNT_ONE;
          default: cnt[r] <= cnt[r];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if (!flush && we && !busy[widx]) begin
      sb_err <= 1'b1;
    end
  end

  assign pending_mask = busy;

endmodule

// File: tb/tb_rr_scoreboard.sv
// Directed self-checking bench for rr_scoreboard; expectations follow the bypass macro.
module tb_rr_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid, src2_is_imm, dst_we, flush, we;
  logic [2:0] src1_idx, src2_idx, dst_idx, widx;
  logic       RR_stall, issue_fire, sb_err;
  logic [7:0] pending_mask;

  int checks   = 0;
  int failures = 0;

  rr_scoreboard #(.NUM_REGS(8), .IDX_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1_idx(src1_idx),
    .src2_idx(src2_idx), .src2_is_imm(src2_is_imm), .dst_we(dst_we), .dst_idx(dst_idx),
    .flush(flush), .we(we), .widx(widx), .RR_stall(RR_stall), .issue_fire(issue_fire),
    .pending_mask(pending_mask), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; src1_idx = 0; src2_idx = 0; src2_is_imm = 1;
    dst_we = 0; dst_idx = 0; flush = 0; we = 0; widx = 0;
  endtask

  // advance one edge, then settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] s1, input logic wr, input logic [2:0] d);
    issue_valid = 1; src1_idx = s1; src2_idx = 0; src2_is_imm = 1;
    dst_we = wr; dst_idx = d;
  endtask

  initial begin
    idle();
    // 1. reset
    step(); step();
    check("rst_pending", pending_mask, 8'h00);
    check("rst_stall", RR_stall, 0);
    check("rst_err", sb_err, 0);
    rst = 0;
    step();
    check("idle_fire", issue_fire, 0);

    // 2. RAW on r3
    issue(0, 1, 3); #1;
    check("t2_fire_dst3", issue_fire, 1);
    step();
    issue(3, 0, 0); #1;
    check("t2_stall", RR_stall, 1);
    check("t2_pending", pending_mask, 8'h08);
    step();
    check("t2_stall_hold", RR_stall, 1);
    we = 1; widx = 3; #1;
`ifdef RR_SCOREBOARD_WB_BYPASS_EN
    check("t2_stall_wb", RR_stall, 0);
`else
    check("t2_stall_wb", RR_stall, 1);
`endif
    step();
    we = 0; #1;
    check("t2_stall_after", RR_stall, 0);
    check("t2_fire_after", issue_fire, 1);
    check("t2_pending_clr", pending_mask, 8'h00);
    idle(); step();

    // 3. saturation on r5
    for (int k = 0; k < 3; k++) begin
      issue(0, 1, 5); #1;
      check("t3_fire", issue_fire, 1);
      step();
    end
    check("t3_pending", pending_mask, 8'h20);
    check("t3_sat_stall", RR_stall, 1);
    step();
    check("t3_sat_hold", RR_stall, 1);
    we = 1; widx = 5; #1;
    check("t3_sat_wb", RR_stall, 1);
    step();
    we = 0; #1;
    check("t3_sat_free", issue_fire, 1);
    step();
    // 4. src2 immediate vs register
    issue_valid = 1; dst_we = 0; src1_idx = 0; src2_idx = 5; src2_is_imm = 1; #1;
    check("t4_imm_fire", issue_fire, 1);
    src2_is_imm = 0; #1;
    check("t4_reg_stall", RR_stall, 1);
    idle();
    we = 1; widx = 5;
    step(); step(); step();
    we = 0; #1;
    check("t4_drained", pending_mask, 8'h00);
    check("t4_no_err", sb_err, 0);

    // 5. simultaneous inc/dec on r2
    issue(0, 1, 2); step();
    we = 1; widx = 2; #1;
    check("t5_fire", issue_fire, 1);
    step();
    idle(); #1;
    check("t5_hold", pending_mask, 8'h04);
    we = 1; widx = 2; step();
    we = 0; #1;
    check("t5_drained", pending_mask, 8'h00);

    // 6. fill all, flush, then retire on empty
    for (int r = 0; r < 8; r++) begin
      issue(3'(r), 1, 3'(r)); #1;
      check("t6_fill_fire", issue_fire, 1);
      step();
    end
    idle(); #1;
    check("t6_full", pending_mask, 8'hFF);
    issue(0, 1, 0); flush = 1; we = 1; widx = 1; #1;
    check("t6_flush_stall", RR_stall, 0);
    check("t6_flush_fire", issue_fire, 0);
    step();
    idle(); #1;
    check("t6_flushed", pending_mask, 8'h00);
    check("t6_flush_no_err", sb_err, 0);
    we = 1; widx = 4; step();
    idle(); #1;
    check("t6_err_set", sb_err, 1);
    check("t6_err_no_cnt", pending_mask, 8'h00);
    issue(0, 1, 6); step();
    we = 1; widx = 6; issue_valid = 0; step();
    idle(); #1;
    check("t6_err_sticky", sb_err, 1);
    issue(0, 1, 6); step();
    issue(6, 0, 0); #1;
    check("t6_pre_rst_stall", RR_stall, 1);
    #2 rst = 1; #1;
    check("t6_async_stall", RR_stall, 0);
    check("t6_async_err", sb_err, 0);
    check("t6_async_pending", pending_mask, 8'h00);
    idle(); step(); rst = 0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
